// File: rtl/fir_pkg.sv
// Shared widths, accumulator type and default coefficient set for the
// 3-parallel polyphase FIR.
package fir_pkg;

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int OUT_W  = 32;

  typedef logic signed [OUT_W-1:0] acc_t;

  // Symmetric 30-tap low-pass; h[0] sits in bits [15:0].
  localparam logic [30*COEF_W-1:0] FIR_COEFFS = {
    16'h000C, 16'hFFE7, 16'h0028, 16'hFFC3, 16'h005A, 16'hFF7E,
    16'h00B9, 16'hFEFC, 16'h0172, 16'hFDE4, 16'h0334, 16'hFA88,
    16'h0C80, 16'h2328, 16'h3A98, 16'h3A98, 16'h2328, 16'h0C80,
    16'hFA88, 16'h0334, 16'hFDE4, 16'h0172, 16'hFEFC, 16'h00B9,
    16'hFF7E, 16'h005A, 16'hFFC3, 16'h0028, 16'hFFE7, 16'h000C
  };

endpackage

// File: rtl/fir_subfilter.sv
// Pipelined direct-form sub-filter running on one polyphase component of the
// input; DLY adds one block of delay for cross-block terms.
module fir_subfilter
  import fir_pkg::*;
#(
  parameter int                     NT    = 10,
  parameter int                     DLY   = 0,
  parameter logic [NT*COEF_W-1:0]   COEFS = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] x_in,
  output acc_t                     y_out
);

  localparam int DL = NT + DLY;

  logic signed [DATA_W-1:0] dl_q [DL];
  logic signed [DATA_W-1:0] dl_d [DL];
  acc_t                     prod_p1_q [NT];
  acc_t                     prod_p1_d [NT];
  acc_t                     sum_p2_q;
  acc_t                     sum_p2_d;

  function automatic logic signed [COEF_W-1:0] coef(input int m);
    return $signed(COEFS[m*COEF_W +: COEF_W]);
  endfunction

  function automatic acc_t mul(input logic signed [DATA_W-1:0] a,
                               input logic signed [COEF_W-1:0] b);
    return acc_t'(a) * acc_t'(b);
  endfunction

  always_comb begin
    dl_d = dl_q;
    if (en) begin
      dl_d[0] = x_in;
      for (int i = 1; i < DL; i++) dl_d[i] = dl_q[i-1];
    end
    // stage p1: one registered product per tap
    for (int m = 0; m < NT; m++) prod_p1_d[m] = mul(dl_q[m+DLY], coef(m));
    // stage p2: registered adder tree, wraps in 32 bits
    sum_p2_d = '0;
    for (int m = 0; m < NT; m++) sum_p2_d = sum_p2_d + prod_p1_q[m];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dl_q      <= '{default: '0};
      prod_p1_q <= '{default: '0};
      sum_p2_q  <= '0;
    end else begin
      dl_q      <= dl_d;
      prod_p1_q <= prod_p1_d;
      sum_p2_q  <= sum_p2_d;
    end
  end

  assign y_out = sum_p2_q;

endmodule

// File: rtl/fir_parallel_pipelined_l3.sv
// Streaming FIR built from a 3-parallel polyphase core: serial-to-parallel
// front end, 9 pipelined sub-filters, parallel-to-serial back end.
module fir_parallel_pipelined_l3
  import fir_pkg::*;
#(
  parameter int                        NTAPS  = 30,
  parameter logic [NTAPS*COEF_W-1:0]   COEFFS = FIR_COEFFS,
  parameter int                        LAT    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] data_in,
  output logic signed [OUT_W-1:0]  data_out
);

  localparam int NT3  = NTAPS / 3;
  localparam int ODLY = LAT - 6;

  if (NTAPS % 3 != 0) begin : g_bad_ntaps
    $error("NTAPS must be a multiple of 3");
  end
  if (LAT < 6) begin : g_bad_lat
    $error("LAT must be at least 6");
  end

  function automatic logic [NT3*COEF_W-1:0] phase_coefs(input int p);
    logic [NT3*COEF_W-1:0] r;
    r = '0;
    for (int m = 0; m < NT3; m++)
      r[m*COEF_W +: COEF_W] = COEFFS[(3*m+p)*COEF_W +: COEF_W];
    return r;
  endfunction

  logic [1:0]               ph_q, ph_d;
  logic signed [DATA_W-1:0] s0_q, s0_d, s1_q, s1_d;
  logic                     blk_en;
  logic signed [DATA_W-1:0] blk_x [3];
  acc_t                     sub_y [9];
  acc_t                     yblk_p3_q [3];
  acc_t                     yblk_p3_d [3];
  acc_t                     out_q [ODLY+1];
  acc_t                     out_d [ODLY+1];

  assign blk_en = (ph_q == 2'd2);

  // The last sample of a block goes straight from the pin into the sub-filters.
  always_comb begin
    ph_d = (ph_q == 2'd2) ? 2'd0 : ph_q + 2'd1;
    s0_d = (ph_q == 2'd0) ? data_in : s0_q;
    s1_d = (ph_q == 2'd1) ? data_in : s1_q;
    blk_x[0] = s0_q;
    blk_x[1] = s1_q;
    blk_x[2] = data_in;
  end

  // Sub-filter (p,q) applies phase-p taps to phase-q samples; p+q>=3 lands
  // in the next block's output and therefore needs one extra block delay.
  for (genvar p = 0; p < 3; p++) begin : g_p
    for (genvar q = 0; q < 3; q++) begin : g_q
      fir_subfilter #(
        .NT   (NT3),
        .DLY  ((p + q >= 3) ? 1 : 0),
        .COEFS(phase_coefs(p))
      ) u_sub (
        .clk  (clk),
        .reset(reset),
        .en   (blk_en),
        .x_in (blk_x[q]),
        .y_out(sub_y[p*3+q])
      );
    end
  end

  always_comb begin
    // stage p3: combine the three contributions for each output phase
    for (int j = 0; j < 3; j++) begin
      yblk_p3_d[j] = '0;
      for (int p = 0; p < 3; p++)
        yblk_p3_d[j] = yblk_p3_d[j] + sub_y[p*3 + ((j - p + 3) % 3)];
    end
    // stage p4: serialize, then pad out to the requested latency
    out_d[0] = yblk_p3_q[ph_q];
    for (int i = 1; i <= ODLY; i++) out_d[i] = out_q[i-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph_q      <= '0;
      s0_q      <= '0;
      s1_q      <= '0;
      yblk_p3_q <= '{default: '0};
      out_q     <= '{default: '0};
    end else begin
      ph_q      <= ph_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      yblk_p3_q <= yblk_p3_d;
      out_q     <= out_d;
    end
  end

  assign data_out = out_q[ODLY];

endmodule

// File: tb/tb_fir_parallel_pipelined_l3.sv
// Bench for the polyphase FIR: three configurations share one input stream and
// are compared against a direct-form convolution model and closed-form tables.
module tb_fir_parallel_pipelined_l3;
  import fir_pkg::*;

  localparam logic [9*16-1:0] H_RAMP = {16'd9, 16'd8, 16'd7, 16'd6, 16'd5,
                                        16'd4, 16'd3, 16'd2, 16'd1};
  localparam logic [9*16-1:0] H_EXT  = {9{16'h8000}};

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic signed [15:0] data_in = '0;
  logic signed [31:0] y_ramp, y_ext, y_dflt;

  always #5 clk = ~clk;

  fir_parallel_pipelined_l3 #(.NTAPS(9), .COEFFS(H_RAMP), .LAT(8)) u_ramp (
    .clk(clk), .reset(reset), .data_in(data_in), .data_out(y_ramp));
  fir_parallel_pipelined_l3 #(.NTAPS(9), .COEFFS(H_EXT), .LAT(6)) u_ext (
    .clk(clk), .reset(reset), .data_in(data_in), .data_out(y_ext));
  fir_parallel_pipelined_l3 u_dflt (
    .clk(clk), .reset(reset), .data_in(data_in), .data_out(y_dflt));

  int xs[$];
  int hc [3][30];
  int nt [3];
  int lat [3];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic signed [31:0] dout(input int w);
    case (w)
      0:       return y_ramp;
      1:       return y_ext;
      default: return y_dflt;
    endcase
  endfunction

  // Direct-form convolution over the history since the last reset release.
  function automatic int model_y(input int w);
    int e, n, acc;
    e   = xs.size() - 1;
    n   = e - lat[w];
    acc = 0;
    if (n < 0) return 0;
    for (int i = 0; i < nt[w]; i++)
      if (n - i >= 0) acc += hc[w][i] * xs[n-i];
    return acc;
  endfunction

  task automatic step(input logic signed [15:0] x);
    data_in = x;
    xs.push_back(int'(x));
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int cycles);
    reset = 1'b0;
    xs.delete();
    repeat (cycles) begin
      data_in = 16'($urandom);
      @(posedge clk);
      #1;
    end
    data_in = '0;
    reset   = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      data_in = 16'($urandom);
      @(posedge clk);
      #1;
      for (int w = 0; w < 3; w++) begin
        n_checks++;
        if (dout(w) !== 32'sd0)
          $display("FAIL reset_out[%0d] c=%0d got %0d expected 0", w, c, dout(w));
        else n_pass++;
      end
    end
    data_in = '0;
    reset   = 1'b1;
    xs.delete();
  endtask

  task automatic test_impulse(input int d);
    int k, ex;
    apply_reset(2);
    for (int e = 0; e < d + 8 + 14; e++) begin
      step((e == d) ? 16'sd1 : 16'sd0);
      k  = e - 8 - d;
      ex = (k >= 0 && k < 9) ? k + 1 : 0;
      n_checks++;
      if (y_ramp !== ex)
        $display("FAIL impulse_d%0d e=%0d got %0d expected %0d", d, e, y_ramp, ex);
      else n_pass++;
      for (int w = 0; w < 3; w++) begin
        ex = model_y(w);
        n_checks++;
        if (dout(w) !== ex)
          $display("FAIL impulse_model[%0d] d=%0d e=%0d got %0d expected %0d",
                   w, d, e, dout(w), ex);
        else n_pass++;
      end
    end
  endtask

  task automatic test_step();
    int k, m, ex;
    apply_reset(2);
    for (int e = 0; e < 30; e++) begin
      step(16'sd1);
      k  = e - 8;
      m  = (k < 0) ? 0 : ((k + 1 > 9) ? 9 : k + 1);
      ex = m * (m + 1) / 2;
      n_checks++;
      if (y_ramp !== ex)
        $display("FAIL step e=%0d got %0d expected %0d", e, y_ramp, ex);
      else n_pass++;
    end
  endtask

  task automatic test_extremes();
    int k, m, ex;
    apply_reset(2);
    for (int e = 0; e < 30; e++) begin
      step(16'sh8000);
      k  = e - 6;
      m  = (k < 0) ? 0 : ((k + 1 > 9) ? 9 : k + 1);
      ex = m * (1 << 30);
      n_checks++;
      if (y_ext !== ex)
        $display("FAIL extremes e=%0d got %0d expected %0d", e, y_ext, ex);
      else n_pass++;
      for (int w = 0; w < 3; w++) begin
        ex = model_y(w);
        n_checks++;
        if (dout(w) !== ex)
          $display("FAIL extremes_model[%0d] e=%0d got %0d expected %0d",
                   w, e, dout(w), ex);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random(input int count);
    int ex;
    apply_reset(2);
    for (int e = 0; e < count; e++) begin
      step(16'($urandom));
      for (int w = 0; w < 3; w++) begin
        ex = model_y(w);
        n_checks++;
        if (dout(w) !== ex)
          $display("FAIL random[%0d] e=%0d got %0d expected %0d", w, e, dout(w), ex);
        else n_pass++;
      end
    end
  endtask

  task automatic test_midstream_reset();
    int ex;
    apply_reset(2);
    for (int e = 0; e < 40; e++) step(16'($urandom));
    #2;
    reset = 1'b0;
    #1;
    for (int w = 0; w < 3; w++) begin
      n_checks++;
      if (dout(w) !== 32'sd0)
        $display("FAIL midreset_async[%0d] got %0d expected 0", w, dout(w));
      else n_pass++;
    end
    xs.delete();
    @(posedge clk);
    #1;
    for (int w = 0; w < 3; w++) begin
      n_checks++;
      if (dout(w) !== 32'sd0)
        $display("FAIL midreset_hold[%0d] got %0d expected 0", w, dout(w));
      else n_pass++;
    end
    reset = 1'b1;
    for (int e = 0; e < 60; e++) begin
      step(16'($urandom));
      for (int w = 0; w < 3; w++) begin
        ex = model_y(w);
        n_checks++;
        if (dout(w) !== ex)
          $display("FAIL midreset_restart[%0d] e=%0d got %0d expected %0d",
                   w, e, dout(w), ex);
        else n_pass++;
      end
    end
  endtask

  initial begin
    logic [30*16-1:0] fc;
    fc = FIR_COEFFS;
    nt  = '{9, 9, 30};
    lat = '{8, 6, 8};
    for (int i = 0; i < 30; i++) begin
      hc[0][i] = i + 1;
      hc[1][i] = -32768;
      hc[2][i] = int'($signed(fc[16*i +: 16]));
    end
    test_reset();
    test_impulse(0);
    test_impulse(1);
    test_impulse(2);
    test_step();
    test_extremes();
    test_random(2000);
    test_midstream_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "bench did not finish");
  end

endmodule
